// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
//   Drives the LED bank: produces an N_LEDS pattern (rotate left, rotate right,
//   flash, hold) advanced by a programmable timebase, plus a registered one-hot
//   colour select taken from debounced-by-edge colour buttons.
//
// Ports
//   clk       system clock, all logic on the rising edge
//   i_reset   synchronous reset, active-high, dominates every other input
//   i_enable  1 = timebase runs; 0 = counter and pattern frozen
//   i_speed   selects tick period LIM0..LIM3 (+1 cycle)
//   i_mode    00 rotate left, 01 rotate right, 10 flash, 11 hold
//   i_btn     raw asynchronous colour buttons, active-high
//   o_led     current pattern
//   o_color   registered one-hot colour select (MSB = red)
//   o_tick    one-cycle pulse on the edge the pattern advances
// -----------------------------------------------------------------------------
module led_sequencer #(
  parameter int          N_LEDS = 4,
  parameter int          COLOR  = 3,
  parameter int          CNT_W  = 32,
  parameter int unsigned LIM0   = 25_000_000,
  parameter int unsigned LIM1   = 12_500_000,
  parameter int unsigned LIM2   = 6_250_000,
  parameter int unsigned LIM3   = 3_125_000
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [1:0]        i_speed,
  input  logic [1:0]        i_mode,
  input  logic [COLOR-1:0]  i_btn,
  output logic [N_LEDS-1:0] o_led,
  output logic [COLOR-1:0]  o_color,
  output logic              o_tick
);

  typedef enum logic [1:0] {
    ST_SHIFT,
    ST_FLASH,
    ST_HOLD
  } state_e;

  localparam logic [1:0] MODE_LEFT  = 2'b00;
  localparam logic [1:0] MODE_FLASH = 2'b10;
  localparam logic [1:0] MODE_HOLD  = 2'b11;

  localparam logic [N_LEDS-1:0] LED_INIT   = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] LED_ONES   = '1;
  localparam logic [COLOR-1:0]  COLOR_INIT = COLOR'(1) << (COLOR - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    counter_q, counter_d;
  logic                tick_q, tick_d;
  logic [N_LEDS-1:0]   led_q, led_d;
  logic [COLOR-1:0]    color_q, color_d;
  logic [COLOR-1:0]    btn_meta_q, btn_sync_q, btn_prev_q;

  logic [CNT_W-1:0]    lim;
  logic [COLOR-1:0]    btn_rise;

  // ---------------------------------------------------------------------------
  // Timebase. The >= compare lets a switch to a shorter period tick on the very
  // next edge instead of running the counter round to 2^CNT_W.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    lim = CNT_W'(LIM0);
    unique case (i_speed)
      2'd0: lim = CNT_W'(LIM0);
      2'd1: lim = CNT_W'(LIM1);
      2'd2: lim = CNT_W'(LIM2);
      2'd3: lim = CNT_W'(LIM3);
    endcase
  end

  always_comb begin
    tick_d    = 1'b0;
    counter_d = counter_q;
    if (i_enable) begin
      if (counter_q >= lim) begin
        tick_d    = 1'b1;
        counter_d = '0;
      end else begin
        counter_d = counter_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pattern FSM: mode is sampled only on tick, so o_led moves on the same edge
  // that o_tick rises.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    if (tick_d) begin
      unique case (i_mode)
        MODE_FLASH: begin
          state_d = ST_FLASH;
          if (state_q != ST_FLASH) led_d = LED_ONES;
          else                     led_d = (led_q == LED_ONES) ? '0 : LED_ONES;
        end
        MODE_HOLD: begin
          state_d = ST_HOLD;
        end
        default: begin
          state_d = ST_SHIFT;
          // Only reachable after FLASH (possibly via HOLD): the pattern is
          // all-ones or all-zeros, so reload a single lit LED instead of
          // rotating garbage.
          if (!$onehot(led_q))         led_d = LED_INIT;
          else if (i_mode == MODE_LEFT) led_d = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
          else                          led_d = {led_q[0], led_q[N_LEDS-1:1]};
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Colour select: rising edges after a 2-flop synchroniser. Simultaneous
  // presses (more than one rising bit) are ignored; held buttons never
  // produce a second rise.
  // ---------------------------------------------------------------------------
  assign btn_rise = btn_sync_q & ~btn_prev_q;

  always_comb begin
    color_d = color_q;
    if ($onehot(btn_rise)) color_d = btn_rise;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (i_reset) begin
      state_q    <= ST_SHIFT;
      counter_q  <= '0;
      tick_q     <= 1'b0;
      led_q      <= LED_INIT;
      color_q    <= COLOR_INIT;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      btn_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      tick_q     <= tick_d;
      led_q      <= led_d;
      color_q    <= color_d;
      btn_meta_q <= i_btn;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
    end
  end

  assign o_led   = led_q;
  assign o_color = color_q;
  assign o_tick  = tick_q;

endmodule

// File: tb/tb_led_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_sequencer
//   Self-checking bench for led_sequencer with short tick periods
//   (LIM0..3 = 7,3,1,0). A cycle model predicts o_led/o_color/o_tick each
//   time inputs are applied; predictions are queued and compared after the
//   edge. Directed checks with fixed constants cover the key sequences.
// -----------------------------------------------------------------------------
module tb_led_sequencer;

  localparam int N_LEDS = 4;
  localparam int COLOR  = 3;
  localparam int LIMS [4] = '{7, 3, 1, 0};

  logic              clk = 1'b0;
  logic              i_reset;
  logic              i_enable;
  logic [1:0]        i_speed;
  logic [1:0]        i_mode;
  logic [COLOR-1:0]  i_btn;
  logic [N_LEDS-1:0] o_led;
  logic [COLOR-1:0]  o_color;
  logic              o_tick;

  led_sequencer #(
    .N_LEDS(N_LEDS), .COLOR(COLOR), .CNT_W(32),
    .LIM0(7), .LIM1(3), .LIM2(1), .LIM3(0)
  ) dut (
    .clk     (clk),
    .i_reset (i_reset),
    .i_enable(i_enable),
    .i_speed (i_speed),
    .i_mode  (i_mode),
    .i_btn   (i_btn),
    .o_led   (o_led),
    .o_color (o_color),
    .o_tick  (o_tick)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [N_LEDS-1:0] led;
    logic [COLOR-1:0]  color;
    logic              tick;
  } exp_t;

  exp_t sb_q[$];

  int                m_cnt;
  bit                m_tick;
  logic [N_LEDS-1:0] m_led;
  logic [COLOR-1:0]  m_color;
  int                m_state;  // 0 shift, 1 flash, 2 hold
  logic [COLOR-1:0]  m_s1, m_s2, m_prev;

  function automatic void model_advance();
    case (i_mode)
      2'b10: begin
        m_led   = (m_state == 1) ? ~m_led : 4'b1111;
        m_state = 1;
      end
      2'b11: m_state = 2;
      default: begin
        if (m_state != 0 && $countones(m_led) != 1) m_led = 4'b0001;
        else if (i_mode == 2'b00) m_led = {m_led[2:0], m_led[3]};
        else                      m_led = {m_led[0], m_led[3:1]};
        m_state = 0;
      end
    endcase
  endfunction

  function automatic void model_step();
    logic [COLOR-1:0] rise;
    if (i_reset) begin
      m_cnt = 0; m_tick = 0; m_led = 4'b0001; m_color = 3'b100;
      m_state = 0; m_s1 = '0; m_s2 = '0; m_prev = '0;
    end else begin
      rise = m_s2 & ~m_prev;
      if ($countones(rise) == 1) m_color = rise;
      m_prev = m_s2;
      m_s2   = m_s1;
      m_s1   = i_btn;
      m_tick = 0;
      if (i_enable) begin
        if (m_cnt >= LIMS[i_speed]) begin
          m_cnt  = 0;
          m_tick = 1;
          model_advance();
        end else begin
          m_cnt++;
        end
      end
    end
    sb_q.push_back('{led: m_led, color: m_color, tick: m_tick});
  endfunction

  // One clock: predict, clock, then compare the queued prediction.
  task automatic step();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("sb_led",   32'(o_led),   32'(e.led));
    check("sb_color", 32'(o_color), 32'(e.color));
    check("sb_tick",  32'(o_tick),  32'(e.tick));
  endtask

  task automatic wait_tick(input string tag, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!o_tick && n < budget);
    check({tag, "_tick_seen"}, 32'(o_tick), 32'd1);
  endtask

  task automatic run_tick(input string tag, input int exp_cycles, input logic [3:0] exp_led);
    int n;
    wait_tick(tag, 20, n);
    check({tag, "_period"}, 32'(n), 32'(exp_cycles));
    check({tag, "_led"}, 32'(o_led), 32'(exp_led));
  endtask

  task automatic hold_btn(input logic [2:0] b, input int cycles);
    i_btn = b;
    repeat (cycles) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset dominates enable and buttons.
    i_reset = 1'b1; i_enable = 1'b1; i_speed = 2'd1; i_mode = 2'b00; i_btn = 3'b111;
    step(); step();
    check("rst_led",   32'(o_led),   32'b0001);
    check("rst_color", 32'(o_color), 32'b100);
    check("rst_tick",  32'(o_tick),  32'd0);

    // Speed 1, rotate left.
    i_reset = 1'b0; i_btn = '0;
    run_tick("l1", 4, 4'b0010);
    run_tick("l2", 4, 4'b0100);
    run_tick("l3", 4, 4'b1000);
    run_tick("l4", 4, 4'b0001);

    // Rotate right.
    i_mode = 2'b01;
    run_tick("r1", 4, 4'b1000);
    run_tick("r2", 4, 4'b0100);
    run_tick("r3", 4, 4'b0010);
    run_tick("r4", 4, 4'b0001);

    // Fastest speed: tick every cycle.
    i_speed = 2'd3;
    run_tick("f0", 1, 4'b1000);

    // Flash for three ticks, then back to shift with a reload.
    i_mode = 2'b10;
    run_tick("fl1", 1, 4'b1111);
    run_tick("fl2", 1, 4'b0000);
    run_tick("fl3", 1, 4'b1111);
    i_mode = 2'b00;
    run_tick("rl1", 1, 4'b0001);
    run_tick("rl2", 1, 4'b0010);

    // Counter at 6 on speed 0, then switch to a shorter limit.
    i_speed = 2'd0;
    repeat (6) step();
    check("slow_no_tick", 32'(o_tick), 32'd0);
    i_speed = 2'd1;
    run_tick("spd_chg", 1, 4'b0100);

    // Enable low: everything frozen.
    i_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("frz_led",  32'(o_led),  32'b0100);
      check("frz_tick", 32'(o_tick), 32'd0);
    end
    i_enable = 1'b1;
    run_tick("unfrz", 4, 4'b1000);

    // Single press: two edges after sampling.
    i_btn = 3'b010;
    step(); check("btn_e0", 32'(o_color), 32'b100);
    step(); check("btn_e1", 32'(o_color), 32'b100);
    step(); check("btn_e2", 32'(o_color), 32'b010);
    hold_btn(3'b010, 2);
    hold_btn(3'b000, 3);

    // Simultaneous presses ignored.
    hold_btn(3'b110, 5);
    check("btn_multi", 32'(o_color), 32'b010);
    hold_btn(3'b000, 3);

    // Press while another is held.
    hold_btn(3'b100, 5);
    check("btn_red", 32'(o_color), 32'b100);
    hold_btn(3'b101, 5);
    check("btn_over", 32'(o_color), 32'b001);
    hold_btn(3'b000, 3);

    // Reach o_led = 0100, counter = 2, with a press in flight, then reset.
    for (int i = 0; i < 6; i++) begin
      wait_tick("seek", 10, n);
      if (o_led == 4'b0100) break;
    end
    check("pre_rst_led", 32'(o_led), 32'b0100);
    i_btn = 3'b010;
    step(); step();
    check("pre_rst_color", 32'(o_color), 32'b001);
    i_reset = 1'b1; i_btn = 3'b000;
    step();
    check("mid_rst_led",   32'(o_led),   32'b0001);
    check("mid_rst_color", 32'(o_color), 32'b100);
    check("mid_rst_tick",  32'(o_tick),  32'd0);
    i_reset = 1'b0;
    run_tick("post_rst", 4, 4'b0010);
    check("post_rst_color", 32'(o_color), 32'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Controller that drives the LED bank block. It generates the N_LEDS pattern (shift left, shift right, flash, hold) at a selectable rate, and produces the one-hot colour select consumed by the LED bank.
- Sits between board switches/buttons and the LED bank: o_led feeds the bank's pattern input, o_color feeds its colour-select input.

Parameters:
- N_LEDS, 4, pattern width.
- COLOR, 3, number of colour channels/buttons (one-hot, MSB = red).
- CNT_W, 32, timebase counter width.
- LIM0, 25_000_000, tick period minus 1 for speed 0 (slowest).
- LIM1, 12_500_000, tick period minus 1 for speed 1.
- LIM2, 6_250_000, tick period minus 1 for speed 2.
- LIM3, 3_125_000, tick period minus 1 for speed 3 (fastest).

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- i_reset  in  1  synchronous reset, active-high.
- i_enable  in  1  1 = timebase runs; 0 = counter and pattern frozen.
- i_speed  in  2  selects LIM0..LIM3.
- i_mode  in  2  00 shift left, 01 shift right, 10 flash, 11 hold.
- i_btn  in  COLOR  raw asynchronous colour buttons, active-high.
- o_led  out  N_LEDS  current pattern.
- o_color  out  COLOR  registered one-hot colour select.
- o_tick  out  1  one-cycle pulse when the pattern advances.

Behaviour:
- Reset is synchronous and active-high: i_reset high at a clk edge forces all of the following, and dominates every other input:
  - counter = 0
  - o_tick = 0
  - o_led = {0..0,1} (LSB lit)
  - o_color = 100 (one-hot, MSB = red; generalised as 1 << (COLOR-1))
  - FSM = SHIFT
  - button synchroniser and edge registers = 0
- Timebase:
  - When i_enable = 1 and counter >= LIM[i_speed]: counter <= 0 and o_tick <= 1 for exactly one cycle.
  - When i_enable = 1 otherwise: counter += 1.
  - When i_enable = 0: counter holds and o_tick = 0.
  - The compare is >= so a speed change to a shorter limit while counter exceeds it produces a tick on the next edge, with no wrap to 2^CNT_W.
  - Tick period is LIM+1 cycles.
- Pattern update happens only in the cycle where the tick is registered; o_led changes on the same edge that o_tick rises.
- Pattern FSM, 3 states; mode is sampled at each tick:
  - SHIFT: mode 00 rotates left (MSB wraps to LSB). Mode 01 rotates right (LSB wraps to MSB).
  - FLASH: o_led alternates all-ones / all-zeros on each tick.
  - HOLD: o_led unchanged.
- FSM transitions, evaluated at tick:
  - Mode 10 from any state -> FLASH; o_led <= all-ones on the entering tick.
  - Mode 11 -> HOLD.
  - Mode 00/01 -> SHIFT. If o_led is not one-hot when entering SHIFT (coming from FLASH or HOLD-after-FLASH), o_led <= {0..0,1} on that tick, with no shift on that tick.
  - A mode change between ticks has no effect until the next tick.
- Colour select:
  - i_btn goes through a 2-flop synchroniser, then a previous-value register. rise = sync & ~prev.
  - If rise is exactly one-hot, o_color <= rise on the next edge.
  - If rise is zero, or has more than one bit set (simultaneous presses), o_color holds.
  - Held buttons do not retrigger.
  - Latency: i_btn stable before edge k -> o_color updated at edge k+2.
  - Colour logic runs regardless of i_enable.
- Reset mid-operation: the whole state returns to reset values on the next edge, including a partially synchronised button press, which is discarded.

Test Plan:
- Bench parameters: LIM0=7, LIM1=3, LIM2=1, LIM3=0, N_LEDS=4.
- Reset, enable=1, speed=1, mode=00 -> o_tick every 4 cycles; o_led 0001 -> 0010 -> 0100 -> 1000 -> 0001.
- Mode=01 from 0001 -> 1000, 0100, 0010, 0001 on successive ticks. Switch to speed=3 -> tick every cycle.
- Mode=10 for 3 ticks, then mode=00 -> 1111, 0000, 1111; next tick reloads 0001; following tick gives 0010.
- Speed=0 with counter at 6, switch to speed=1 -> tick on the next edge, counter resets to 0. Enable=0 for 10 cycles -> o_led and counter frozen, o_tick=0.
- Button presses, each held 5 cycles:
  - Press 010 -> o_color 010 two edges after sampling.
  - Press 110 simultaneously -> o_color stays 010.
  - Press 001 while 100 is held -> o_color 001.
- Assert i_reset one cycle mid-pattern (o_led=0100, o_color=001, counter=2) -> next edge: o_led=0001, o_color=100, counter=0, o_tick=0.
